ex_stage: RTL

- Execute stage of the 5-stage pipeline. Sits between ID and MEM.
- Registers the ID->EX bus and computes the ALU result; multi-cycle divides run in a 32-iteration sequential divider.
- Drives the data SRAM request: enable, byte-lane write enables, address and write data.
- Produces the 80-bit EX->MEM bus, the ID forwarding bus and a stall request.

---
 rtl/ex_stage_if.sv | 26 ++
 rtl/ex_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX input bus, EX/MEM output bus, ID feedback and data SRAM request.
// slave = the execute stage, master = the surrounding pipeline/bench.
interface ex_stage_if;
  logic [5:0]   stall;
  logic [144:0] id_to_ex_bus;
  logic [79:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id;
  logic         ex_is_load;
  logic         stallreq_for_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ID/EX register, ALU, sequential restoring divider, data SRAM request.
// Optional: EX_DIV_ZERO_FAST_EN finishes divide-by-zero in one cycle instead of DIV_ITER+1.
module ex_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);
  localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_e;

  logic [144:0] r_bus;
  div_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic         r_done_flag, r_neg_q, r_neg_r;
  logic [31:0]  r_quot, r_rem, r_dvs;

  logic         w_reg_upd;
  logic [3:0]   w_mem_kind, w_alu_op;
  logic [1:0]   w_store_kind;
  logic         w_sel, w_rf_we;
  logic [4:0]   w_waddr;
  logic [31:0]  w_pc, w_src1, w_src2, w_sd;
  logic         w_is_div, w_signed, w_stallreq;
  logic [31:0]  w_abs1, w_abs2, w_div_res, w_res;
  logic [32:0]  w_sh, w_diff;
  logic         w_ge;
  logic         w_en;
  logic [3:0]   w_wen;
  logic [31:0]  w_wdata;
  logic         w_unused;

  assign w_unused = ^{bus.stall[5:4], bus.stall[1:0]};

  // EX stopped with MEM running inserts a bubble; EX running loads.
  always_ff @(posedge clk) begin
    if (rst)                                r_bus <= '0;
    else if (bus.stall[2] && !bus.stall[3]) r_bus <= '0;
    else if (!bus.stall[2])                 r_bus <= bus.id_to_ex_bus;
  end
  assign w_reg_upd = !bus.stall[2] || !bus.stall[3];

  assign {w_mem_kind, w_store_kind, w_alu_op, w_sel, w_rf_we, w_waddr,
          w_pc, w_src1, w_src2, w_sd} = r_bus;

  assign w_is_div = (w_alu_op[3:2] == 2'b11);
  assign w_signed = w_is_div && !w_alu_op[0];
  assign w_abs1   = (w_signed && w_src1[31]) ? -w_src1 : w_src1;
  assign w_abs2   = (w_signed && w_src2[31]) ? -w_src2 : w_src2;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_sh   = {r_rem, r_quot[31]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  assign w_ge   = !w_diff[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_done_flag <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_is_div && !r_done_flag) begin
          r_cnt   <= '0;
          r_dvs   <= w_abs2;
          r_neg_q <= w_signed && (w_src1[31] ^ w_src2[31]) && (w_src2 != '0);
          r_neg_r <= w_signed && w_src1[31];
`ifdef EX_DIV_ZERO_FAST_EN
          if (w_src2 == '0) begin
            r_quot  <= '1;
            r_rem   <= w_abs1;
            r_state <= S_DONE;
          end else begin
            r_quot  <= w_abs1;
            r_rem   <= '0;
            r_state <= S_RUN;
          end
`else
          r_quot  <= w_abs1;
          r_rem   <= '0;
          r_state <= S_RUN;
`endif
        end
        S_RUN: begin
          r_quot <= {r_quot[30:0], w_ge};
          r_rem  <= w_ge ? w_diff[31:0] : w_sh[31:0];
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(DIV_ITER - 1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A fresh instruction (or bubble) must be allowed to start a new divide.
      if (w_reg_upd)              r_done_flag <= 1'b0;
      else if (r_state == S_DONE) r_done_flag <= 1'b1;
    end
  end

  assign w_div_res  = w_alu_op[1] ? (r_neg_r ? -r_rem : r_rem)
                                  : (r_neg_q ? -r_quot : r_quot);
  assign w_stallreq = w_is_div && (r_state != S_DONE) && !r_done_flag;

  always_comb begin
    w_res = '0;
    case (w_alu_op)
      4'd0:  w_res = w_src1 + w_src2;
      4'd1:  w_res = w_src1 - w_src2;
      4'd2:  w_res = w_src1 & w_src2;
      4'd3:  w_res = w_src1 | w_src2;
      4'd4:  w_res = w_src1 ^ w_src2;
      4'd5:  w_res = ~(w_src1 | w_src2);
      4'd6:  w_res = w_src2 << w_src1[4:0];
      4'd7:  w_res = w_src2 >> w_src1[4:0];
      4'd8:  w_res = $signed(w_src2) >>> w_src1[4:0];
      4'd9:  w_res = {31'd0, $signed(w_src1) < $signed(w_src2)};
      4'd10: w_res = {31'd0, w_src1 < w_src2};
      4'd11: w_res = {w_src2[15:0], 16'd0};
      default: w_res = w_div_res;
    endcase
  end

  // Misaligned sh/sw keep the access enabled but suppress every byte lane.
  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = '0;
    case (w_store_kind)
      2'b01: begin
        w_wen   = 4'b0001 << w_res[1:0];
        w_wdata = {4{w_sd[7:0]}};
      end
      2'b10: begin
        w_wen   = (w_res[1:0] == 2'b00) ? 4'b0011 :
                  (w_res[1:0] == 2'b10) ? 4'b1100 : 4'b0000;
        w_wdata = {2{w_sd[15:0]}};
      end
      2'b11: begin
        w_wen   = (w_res[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
        w_wdata = w_sd;
      end
      default: ;
    endcase
  end
  assign w_en = (w_mem_kind != 4'd0) || (w_store_kind != 2'd0);

  assign bus.data_sram_en    = w_en;
  assign bus.data_sram_wen   = w_wen;
  assign bus.data_sram_addr  = w_res;
  assign bus.data_sram_wdata = w_wdata;
  assign bus.ex_is_load      = (w_mem_kind != 4'd0);
  assign bus.stallreq_for_ex = w_stallreq;
  assign bus.ex_to_id        = {w_rf_we, w_waddr, w_res};
  assign bus.ex_to_mem_bus   = {w_mem_kind, w_pc, w_en && !w_stallreq, w_wen,
                                w_sel, w_rf_we && !w_stallreq, w_waddr, w_res};
endmodule
